// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. It issues one-word reads to a fixed-latency memory,
// holds the fetched word for the decoder until it is accepted, then advances the PC.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   en                 run enable; a new fetch starts only while high
//   mem_en, mem_ren    memory enable / read enable, high for the one-cycle request
//   mem_addr[15:0]     word address (pc[17:2])
//   mem_dout[31:0]     read data, sampled only in the capture cycle
//   instr[31:0]        fetched instruction
//   instr_valid        instr holds a word not yet consumed
//   instr_ready        decoder accepts instr this cycle
//   pc[31:0]           address of instr, or of the fetch in flight
//   redirect           taken jump/branch; load redirect_pc
//   redirect_pc[31:0]  new PC, bits [1:0] forced to zero
//   IF                 high while a fetch is in flight (REQ or WAIT)
module fetch_unit #(
    parameter int unsigned MEM_LAT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        mem_en,
    output logic        mem_ren,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        IF
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [31:0] redirect_target;
    logic        unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                // A redirect while idle only moves the PC; the fetch starts next cycle.
                if (redirect) begin
                    pc_d = redirect_target;
                end else if (en) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = en ? StReq : StIdle;
                end else begin
                    cnt_d   = 4'(MEM_LAT);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect) begin
                    // Abandon the in-flight read; its data is never captured.
                    pc_d    = redirect_target;
                    cnt_d   = 4'd0;
                    state_d = en ? StReq : StIdle;
                end else if (cnt_q <= 4'd1) begin
                    instr_d = mem_dout;
                    valid_d = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                // Redirect wins over a simultaneous handshake: no pc+4.
                if (redirect) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    state_d = en ? StReq : StIdle;
                end else if (valid_q && instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    state_d = en ? StReq : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_en      = (state_q == StReq);
    assign mem_ren     = mem_en;
    assign mem_addr    = pc_q[17:2];
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign IF          = (state_q == StReq) || (state_q == StWait);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mem_en;
    logic        mem_ren;
    logic [15:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_flag;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .MEM_LAT (MEM_LAT),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mem_en     (mem_en),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc         (pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .IF         (if_flag)
    );

    always #5 clk = ~clk;

    // Memory: data for a request is valid only in the cycle ending MEM_LAT edges after the
    // request edge; every other cycle shows a garbage pattern.
    logic [15:0] rd_addr  = 16'h0;
    int unsigned lat_cnt  = 0;
    logic        force_on = 1'b0;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return (a == 16'h0) ? 32'h2008_0005 : {16'hC0DE, a};
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            rd_addr <= mem_addr;
            lat_cnt <= MEM_LAT;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
        end
    end

    assign mem_dout = force_on ? 32'hDEAD_BEEF :
                      (lat_cnt == 1) ? mem_word(rd_addr) : 32'hBAD0_0BAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_if", 32'(if_flag), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);

        // First fetch from address 0.
        rst = 1'b0; en = 1'b1;
        tick();
        chk("req0_mem_en", 32'(mem_en), 32'd1);
        chk("req0_mem_ren", 32'(mem_ren), 32'd1);
        chk("req0_addr", 32'(mem_addr), 32'h0);
        chk("req0_if", 32'(if_flag), 32'd1);
        tick();
        chk("wait0_mem_en", 32'(mem_en), 32'd0);
        chk("wait0_if", 32'(if_flag), 32'd1);
        chk("wait0_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("wait0b_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("f0_valid", 32'(instr_valid), 32'd1);
        chk("f0_instr", instr, 32'h2008_0005);
        chk("f0_pc", pc, 32'h0);
        chk("f0_if", 32'(if_flag), 32'd0);

        // Decoder stalls for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_instr", instr, 32'h2008_0005);
            chk("stall_pc", pc, 32'h0);
            chk("stall_valid", 32'(instr_valid), 32'd1);
        end
        instr_ready = 1'b1;
        tick();
        chk("hs0_valid", 32'(instr_valid), 32'd0);
        chk("hs0_pc", pc, 32'h4);
        chk("hs0_mem_en", 32'(mem_en), 32'd1);
        chk("hs0_addr", 32'(mem_addr), 32'h1);
        instr_ready = 1'b0;
        tick(); tick(); tick();
        chk("f1_valid", 32'(instr_valid), 32'd1);
        chk("f1_instr", instr, 32'hC0DE_0001);

        // Accept, then redirect during the WAIT of the next fetch.
        instr_ready = 1'b1;
        tick();
        chk("hs1_pc", pc, 32'h8);
        chk("hs1_addr", 32'(mem_addr), 32'h2);
        instr_ready = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0043;
        tick();
        redirect = 1'b0;
        chk("rdw_pc", pc, 32'h0000_0040);
        chk("rdw_valid", 32'(instr_valid), 32'd0);
        chk("rdw_instr", instr, 32'hC0DE_0001);
        chk("rdw_mem_en", 32'(mem_en), 32'd1);
        chk("rdw_addr", 32'(mem_addr), 32'h0010);
        tick(); tick();
        chk("rdw_no_capture", 32'(instr_valid), 32'd0);
        tick();
        chk("f10_valid", 32'(instr_valid), 32'd1);
        chk("f10_instr", instr, 32'hC0DE_0010);

        // Redirect to 8 from HOLD, fetch it, then redirect+handshake together.
        redirect = 1'b1; redirect_pc = 32'h8;
        tick();
        redirect = 1'b0;
        chk("rdh_pc", pc, 32'h8);
        tick(); tick(); tick();
        chk("f2_instr", instr, 32'hC0DE_0002);
        redirect = 1'b1; redirect_pc = 32'h100; instr_ready = 1'b1;
        tick();
        redirect = 1'b0; instr_ready = 1'b0;
        chk("rdhs_pc", pc, 32'h100);
        chk("rdhs_valid", 32'(instr_valid), 32'd0);
        chk("rdhs_addr", 32'(mem_addr), 32'h0040);

        // en drops during the fetch: it completes, but no new fetch after handshake.
        en = 1'b0;
        tick(); tick(); tick();
        chk("enoff_valid", 32'(instr_valid), 32'd1);
        chk("enoff_instr", instr, 32'hC0DE_0040);
        instr_ready = 1'b1;
        tick();
        chk("enoff_pc", pc, 32'h104);
        chk("enoff_mem_en", 32'(mem_en), 32'd0);
        chk("enoff_if", 32'(if_flag), 32'd0);
        tick();
        chk("idle_ready_pc", pc, 32'h104);
        chk("idle_ready_valid", 32'(instr_valid), 32'd0);
        instr_ready = 1'b0;

        // Redirect in IDLE, then PC wrap on handshake.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        chk("rdi_pc", pc, 32'hFFFF_FFFC);
        chk("rdi_if", 32'(if_flag), 32'd0);
        en = 1'b1;
        tick();
        chk("wrap_req_addr", 32'(mem_addr), 32'hFFFF);
        tick(); tick(); tick();
        chk("wrap_instr", instr, 32'hC0DE_FFFF);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_addr", 32'(mem_addr), 32'h0);
        chk("wrap_mem_en", 32'(mem_en), 32'd1);

        // Reset during WAIT; a late response must be discarded.
        tick();
        chk("pre_rst_if", 32'(if_flag), 32'd1);
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
        tick();
        rst = 1'b0; redirect = 1'b0; instr_ready = 1'b0; en = 1'b0; force_on = 1'b1;
        chk("wrst_pc", pc, 32'h0);
        chk("wrst_if", 32'(if_flag), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrst_valid", 32'(instr_valid), 32'd0);
            chk("wrst_instr", instr, 32'h0);
        end
        force_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
